// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers
// Optional message lock keeps a requester granted until ReqLast: define TX_ARB_LOCK_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [NUM_REQ-1:0]   ReqValid,
    input  logic [8*NUM_REQ-1:0] ReqData,
    input  logic [NUM_REQ-1:0]   ReqLast,
    output logic [NUM_REQ-1:0]   ReqAck,
    input  logic                 TxEmpty,
    output logic                 XMitGo,
    output logic [7:0]           TxData,
    output logic [NUM_REQ-1:0]   Grant,
    output logic                 TimeoutErr
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(ACK_TIMEOUT);
    localparam logic [PW:0]   NUM_EXT  = (PW+1)'(NUM_REQ);

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_SEND  = 2'd1;
    localparam logic [1:0] ARB_DRAIN = 2'd2;

    logic [1:0]         state;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      owner;
    logic [PW-1:0]      owner_next;
    logic [PW-1:0]      win_idx;
    logic               win_found;
    logic [PW:0]        probe;
    logic [CW-1:0]      cnt;
    logic [NUM_REQ-1:0] eligible;

    assign owner_next = (owner == LAST_IDX) ? '0 : owner + PW'(1);

`ifdef TX_ARB_LOCK_EN
    logic locked;
    logic last_q;

    // While locked only the current owner may win, and it is waited for indefinitely.
    always_comb begin
        eligible = ReqValid;
        if (locked) begin
            eligible = ReqValid & (NUM_REQ'(1) << owner);
        end
    end
`else
    logic unused_last;
    assign unused_last = ^ReqLast;
    assign eligible    = ReqValid;
`endif

    // Walk downward so the lowest offset from ptr is the final (winning) assignment.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        probe     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            probe = {1'b0, ptr} + (PW+1)'(k);
            if (probe >= NUM_EXT) begin
                probe = probe - NUM_EXT;
            end
            if (eligible[probe[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = probe[PW-1:0];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= ARB_IDLE;
            ptr        <= '0;
            owner      <= '0;
            cnt        <= '0;
            XMitGo     <= 1'b0;
            TxData     <= 8'h00;
            Grant      <= '0;
            ReqAck     <= '0;
            TimeoutErr <= 1'b0;
`ifdef TX_ARB_LOCK_EN
            locked     <= 1'b0;
            last_q     <= 1'b0;
`endif
        end else begin
            ReqAck     <= '0;
            TimeoutErr <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (TxEmpty && win_found) begin
                        owner  <= win_idx;
                        TxData <= ReqData[8*win_idx +: 8];
                        Grant  <= NUM_REQ'(1) << win_idx;
                        cnt    <= '0;
                        XMitGo <= 1'b1;
                        state  <= ARB_SEND;
`ifdef TX_ARB_LOCK_EN
                        last_q <= ReqLast[win_idx];
`endif
                    end
                end
                ARB_SEND: begin
                    // An acknowledge on the final watchdog cycle takes priority over the abort.
                    if (!TxEmpty) begin
                        ReqAck <= Grant;
                        XMitGo <= 1'b0;
                        state  <= ARB_DRAIN;
                    end else if (cnt == CNT_MAX) begin
                        XMitGo     <= 1'b0;
                        TimeoutErr <= 1'b1;
                        ptr        <= owner_next;
                        Grant      <= '0;
                        state      <= ARB_IDLE;
`ifdef TX_ARB_LOCK_EN
                        locked     <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ARB_DRAIN: begin
                    if (TxEmpty) begin
                        Grant <= '0;
                        state <= ARB_IDLE;
`ifdef TX_ARB_LOCK_EN
                        if (last_q) begin
                            ptr    <= owner_next;
                            locked <= 1'b0;
                        end else begin
                            locked <= 1'b1;
                        end
`else
                        ptr   <= owner_next;
`endif
                    end
                end
                default: begin
                    XMitGo <= 1'b0;
                    Grant  <= '0;
                    state  <= ARB_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int NR  = 4;
    localparam int TMO = 15;

    logic            Clock = 1'b0;
    logic            Reset = 1'b1;
    logic [NR-1:0]   ReqValid = '0;
    logic [8*NR-1:0] ReqData = '0;
    logic [NR-1:0]   ReqLast = '0;
    logic            TxEmpty = 1'b1;
    logic [NR-1:0]   ReqAck;
    logic            XMitGo;
    logic [7:0]      TxData;
    logic [NR-1:0]   Grant;
    logic            TimeoutErr;

    uart_tx_arbiter #(.NUM_REQ(NR), .ACK_TIMEOUT(TMO)) dut (
        .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqData(ReqData),
        .ReqLast(ReqLast), .ReqAck(ReqAck), .TxEmpty(TxEmpty), .XMitGo(XMitGo),
        .TxData(TxData), .Grant(Grant), .TimeoutErr(TimeoutErr)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int uart_delay = 2;
    int uart_busy = 2;
    int go_cnt = 0;
    int busy_cnt = 0;
    bit uart_stuck = 1'b0;
    int ack_cnt [NR];
    logic [NR-1:0] auto_drop = '0;
    int ack_log [$];
    int ack_cyc [$];

    function automatic int oh_idx(input logic [NR-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NR; i++) if (v[i]) r = i;
        return r;
    endfunction

    // One clock, then the UART and requester models react to the post-edge outputs.
    task automatic step();
        @(posedge Clock);
        #1;
        cyc++;
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) TxEmpty = 1'b1;
        end
        if (XMitGo && !uart_stuck && busy_cnt == 0 && TxEmpty) begin
            go_cnt++;
            if (go_cnt >= uart_delay) begin
                TxEmpty  = 1'b0;
                busy_cnt = uart_busy;
                go_cnt   = 0;
            end
        end else if (!XMitGo) begin
            go_cnt = 0;
        end
        for (int i = 0; i < NR; i++) begin
            if (ReqAck[i]) begin
                ack_cnt[i]++;
                ack_log.push_back(i);
                ack_cyc.push_back(cyc);
                if (auto_drop[i]) ReqValid[i] = 1'b0;
                else ReqData[8*i +: 8] = 8'(8'hA0 + 16*i + ack_cnt[i]);
            end
        end
    endtask

    task automatic uart_reset();
        TxEmpty  = 1'b1;
        go_cnt   = 0;
        busy_cnt = 0;
    endtask

    task automatic clear_log();
        for (int i = 0; i < NR; i++) ack_cnt[i] = 0;
        ack_log.delete();
        ack_cyc.delete();
    endtask

    task automatic load_all();
        for (int i = 0; i < NR; i++) ReqData[8*i +: 8] = 8'(8'hA0 + 16*i);
    endtask

    task automatic drain(input string name);
        int t;
        for (t = 0; t < 60; t++) begin
            if (Grant == '0 && !XMitGo && TxEmpty && busy_cnt == 0) break;
            step();
        end
        n_cmp++;
        if (t == 60) begin
            n_fail++;
            $display("FAIL %s_drain: Grant=%b XMitGo=%b, idle expected within 60 cycles", name, Grant, XMitGo);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        ReqValid = '1;
        load_all();
        uart_reset();
        step();
        step();
        n_cmp++; if (XMitGo !== 1'b0) begin n_fail++; $display("FAIL reset_xmitgo: got %b want 0", XMitGo); end
        n_cmp++; if (TxData !== 8'h00) begin n_fail++; $display("FAIL reset_txdata: got %h want 00", TxData); end
        n_cmp++; if (Grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", Grant); end
        n_cmp++; if (ReqAck !== 4'b0000) begin n_fail++; $display("FAIL reset_reqack: got %b want 0000", ReqAck); end
        n_cmp++; if (TimeoutErr !== 1'b0) begin n_fail++; $display("FAIL reset_timeouterr: got %b want 0", TimeoutErr); end
        ReqValid = '0;
        Reset = 1'b0;
        for (int t = 0; t < 3; t++) begin
            step();
            n_cmp++; if (Grant !== 4'b0000 || XMitGo !== 1'b0) begin n_fail++; $display("FAIL idle_no_valid: Grant=%b XMitGo=%b want 0000/0", Grant, XMitGo); end
        end
    endtask

    task automatic test_single();
        int hi;
        clear_log();
        uart_delay = 2;
        uart_busy  = 2;
        auto_drop  = 4'b0010;
        ReqData[15:8] = 8'h48;
        ReqValid = 4'b0010;
        step();
        n_cmp++; if (XMitGo !== 1'b1) begin n_fail++; $display("FAIL single_xmitgo: got %b want 1", XMitGo); end
        n_cmp++; if (TxData !== 8'h48) begin n_fail++; $display("FAIL single_txdata: got %h want 48", TxData); end
        n_cmp++; if (Grant !== 4'b0010) begin n_fail++; $display("FAIL single_grant: got %b want 0010", Grant); end
        hi = 1;
        for (int t = 0; t < 20; t++) begin
            step();
            if (XMitGo) hi++;
            if (Grant == '0) break;
        end
        n_cmp++; if (hi !== 2) begin n_fail++; $display("FAIL single_xmit_cycles: got %0d want 2", hi); end
        n_cmp++; if (ack_cnt[1] !== 1 || ack_log.size() !== 1) begin n_fail++; $display("FAIL single_acks: ack1=%0d total=%0d want 1/1", ack_cnt[1], ack_log.size()); end
    endtask

    task automatic test_reset_mid_send();
        auto_drop = '0;
        load_all();
        ReqValid = '1;
        step();
        n_cmp++; if (Grant !== 4'b0100) begin n_fail++; $display("FAIL ptr_after_single: got %b want 0100", Grant); end
        n_cmp++; if (XMitGo !== 1'b1) begin n_fail++; $display("FAIL midsend_xmitgo: got %b want 1", XMitGo); end
        Reset = 1'b1;
        uart_reset();
        step();
        n_cmp++; if (XMitGo !== 1'b0 || Grant !== 4'b0000 || TxData !== 8'h00) begin n_fail++; $display("FAIL midsend_reset: XMitGo=%b Grant=%b TxData=%h want 0/0000/00", XMitGo, Grant, TxData); end
        n_cmp++; if (ReqAck !== 4'b0000 || TimeoutErr !== 1'b0) begin n_fail++; $display("FAIL midsend_noack: ReqAck=%b TimeoutErr=%b want 0000/0", ReqAck, TimeoutErr); end
        Reset = 1'b0;
        uart_delay = 1;
        uart_busy  = 1;
        clear_log();
        step();
        n_cmp++; if (Grant !== 4'b0001 || TxData !== 8'hA0) begin n_fail++; $display("FAIL post_reset_grant: Grant=%b TxData=%h want 0001/a0", Grant, TxData); end
    endtask

    task automatic test_fairness();
        logic [NR-1:0] prev;
        int idx;
        prev = Grant;
        for (int t = 0; t < 100 && ack_log.size() < 8; t++) begin
            step();
            if (Grant != '0 && prev == '0) begin
                idx = oh_idx(Grant);
                n_cmp++; if (idx >= 0 && TxData !== 8'(8'hA0 + 16*idx + ack_cnt[idx])) begin n_fail++; $display("FAIL fair_txdata: req%0d got %h want %h", idx, TxData, 8'(8'hA0 + 16*idx + ack_cnt[idx])); end
            end
            prev = Grant;
        end
        ReqValid = '0;
        n_cmp++; if (ack_log.size() !== 8) begin n_fail++; $display("FAIL fair_count: got %0d acks want 8", ack_log.size()); end
        for (int j = 0; j < 8 && j < ack_log.size(); j++) begin
            n_cmp++; if (ack_log[j] !== j % 4) begin n_fail++; $display("FAIL fair_order%0d: got req%0d want req%0d", j, ack_log[j], j % 4); end
            if (j > 0) begin
                n_cmp++; if (ack_cyc[j] - ack_cyc[j-1] !== 3) begin n_fail++; $display("FAIL fair_turnaround%0d: got %0d cycles want 3", j, ack_cyc[j] - ack_cyc[j-1]); end
            end
        end
        for (int i = 0; i < NR; i++) begin
            n_cmp++; if (ack_cnt[i] !== 2) begin n_fail++; $display("FAIL fair_acks_req%0d: got %0d want 2", i, ack_cnt[i]); end
        end
        drain("fair");
    endtask

    task automatic test_timeout();
        int hi;
        clear_log();
        uart_stuck = 1'b1;
        ReqData[23:16] = 8'h5A;
        ReqValid = 4'b0100;
        step();
        n_cmp++; if (Grant !== 4'b0100 || TxData !== 8'h5A) begin n_fail++; $display("FAIL tmo_grant: Grant=%b TxData=%h want 0100/5a", Grant, TxData); end
        hi = 1;
        for (int t = 0; t < 40; t++) begin
            step();
            if (XMitGo) hi++;
            else break;
        end
        n_cmp++; if (hi !== TMO + 1) begin n_fail++; $display("FAIL tmo_xmit_cycles: got %0d want %0d", hi, TMO + 1); end
        n_cmp++; if (TimeoutErr !== 1'b1 || ReqAck !== 4'b0000 || Grant !== 4'b0000) begin n_fail++; $display("FAIL tmo_abort: TimeoutErr=%b ReqAck=%b Grant=%b want 1/0000/0000", TimeoutErr, ReqAck, Grant); end
        uart_stuck = 1'b0;
        uart_delay = 1;
        uart_busy  = 1;
        load_all();
        ReqValid = '1;
        step();
        n_cmp++; if (TimeoutErr !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse_width: got %b want 0", TimeoutErr); end
        n_cmp++; if (Grant !== 4'b1000) begin n_fail++; $display("FAIL tmo_next_grant: got %b want 1000", Grant); end
        for (int t = 0; t < 20 && ack_log.size() == 0; t++) step();
        ReqValid = '0;
        n_cmp++; if (ack_log.size() !== 1 || ack_cnt[3] !== 1 || ack_cnt[2] !== 0) begin n_fail++; $display("FAIL tmo_acks: total=%0d ack3=%0d ack2=%0d want 1/1/0", ack_log.size(), ack_cnt[3], ack_cnt[2]); end
        drain("tmo");
    endtask

    task automatic test_ack_on_timeout();
        int hi;
        int terr;
        clear_log();
        uart_delay = TMO + 1;
        uart_busy  = 2;
        auto_drop  = 4'b0001;
        ReqData[7:0] = 8'h3C;
        ReqValid = 4'b0001;
        step();
        n_cmp++; if (Grant !== 4'b0001 || TxData !== 8'h3C) begin n_fail++; $display("FAIL edge_grant: Grant=%b TxData=%h want 0001/3c", Grant, TxData); end
        hi = 1;
        terr = 0;
        for (int t = 0; t < 40; t++) begin
            step();
            if (TimeoutErr) terr++;
            if (XMitGo) hi++;
            else break;
        end
        n_cmp++; if (hi !== TMO + 1) begin n_fail++; $display("FAIL edge_xmit_cycles: got %0d want %0d", hi, TMO + 1); end
        n_cmp++; if (ReqAck !== 4'b0001 || terr !== 0) begin n_fail++; $display("FAIL edge_ack_wins: ReqAck=%b timeouts=%0d want 0001/0", ReqAck, terr); end
        drain("edge");
        n_cmp++; if (ack_cnt[0] !== 1) begin n_fail++; $display("FAIL edge_ack_count: got %0d want 1", ack_cnt[0]); end
    endtask

    task automatic test_txempty_low_idle();
        clear_log();
        uart_delay = 2;
        uart_busy  = 2;
        auto_drop  = '1;
        load_all();
        TxEmpty  = 1'b0;
        busy_cnt = 3;
        ReqValid = '1;
        for (int t = 0; t < 3; t++) begin
            step();
            n_cmp++; if (Grant !== 4'b0000) begin n_fail++; $display("FAIL busy_no_grant%0d: got %b want 0000", t, Grant); end
        end
        step();
        n_cmp++; if (Grant !== 4'b0010 || TxData !== 8'hB0) begin n_fail++; $display("FAIL busy_then_grant: Grant=%b TxData=%h want 0010/b0", Grant, TxData); end
        ReqValid = '0;
        drain("busy");
        n_cmp++; if (ack_cnt[1] !== 1 || ack_log.size() !== 1) begin n_fail++; $display("FAIL dropped_valid_ack: ack1=%0d total=%0d want 1/1", ack_cnt[1], ack_log.size()); end
    endtask

`ifdef TX_ARB_LOCK_EN
    task automatic test_lock();
        int glog [$];
        logic [7:0] dlog [$];
        logic [NR-1:0] prev;
        int k;
        logic [7:0] exp_d [4];
        int exp_g [4];
        exp_d[0] = 8'h48; exp_d[1] = 8'h69; exp_d[2] = 8'h0A; exp_d[3] = 8'h30;
        exp_g[0] = 1; exp_g[1] = 1; exp_g[2] = 1; exp_g[3] = 0;
        Reset = 1'b1;
        uart_reset();
        step();
        Reset = 1'b0;
        clear_log();
        uart_delay = 1;
        uart_busy  = 1;
        auto_drop  = 4'b0001;
        ReqData[15:8] = 8'h48;
        ReqLast = '0;
        ReqValid = 4'b0010;
        step();
        glog.push_back(oh_idx(Grant));
        dlog.push_back(TxData);
        ReqData[7:0] = 8'h30;
        ReqLast[0] = 1'b1;
        ReqValid = 4'b0011;
        prev = Grant;
        k = 0;
        for (int t = 0; t < 100 && glog.size() < 4; t++) begin
            step();
            if (ReqAck[1]) begin
                k++;
                if (k == 1) begin ReqData[15:8] = 8'h69; ReqLast[1] = 1'b0; end
                if (k == 2) begin ReqData[15:8] = 8'h0A; ReqLast[1] = 1'b1; end
                if (k == 3) ReqValid[1] = 1'b0;
            end
            if (Grant != '0 && prev == '0) begin
                glog.push_back(oh_idx(Grant));
                dlog.push_back(TxData);
            end
            prev = Grant;
        end
        n_cmp++; if (glog.size() !== 4) begin n_fail++; $display("FAIL lock_grants: got %0d want 4", glog.size()); end
        for (int j = 0; j < 4 && j < glog.size(); j++) begin
            n_cmp++; if (glog[j] !== exp_g[j] || dlog[j] !== exp_d[j]) begin n_fail++; $display("FAIL lock_seq%0d: req%0d data %h want req%0d data %h", j, glog[j], dlog[j], exp_g[j], exp_d[j]); end
        end
        ReqValid = '0;
        drain("lock");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_reset_mid_send();
        test_fairness();
        test_timeout();
        test_ack_on_timeout();
        test_txempty_low_idle();
`ifdef TX_ARB_LOCK_EN
        test_lock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
